// File: rtl/register_bank_sb.sv
// register_bank_sb: N_REG x N_BIT register bank with two combinational read
// ports, one synchronous write port and a per-register pending-write
// scoreboard (busy bits plus a running count of pending registers).
// Register 0 is hardwired to zero and can never be marked pending.
// Optional feature macro: REG_BYPASS_EN (write-through forwarding of the
// same-cycle write onto the read ports).
module register_bank_sb #(
  parameter int unsigned N_ADDR = 5,
  parameter int unsigned N_BIT  = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [N_ADDR-1:0] Rd_reg_1,
  input  logic [N_ADDR-1:0] Rd_reg_2,
  output logic [N_BIT-1:0]  Rd_data_1,
  output logic [N_BIT-1:0]  Rd_data_2,
  output logic              Rd_busy_1,
  output logic              Rd_busy_2,
  input  logic [N_ADDR-1:0] Wr_reg,
  input  logic [N_BIT-1:0]  Wr_data,
  input  logic              Reg_write,
  input  logic [N_ADDR-1:0] Iss_reg,
  input  logic              Iss_valid,
  input  logic              Flush,
  output logic [N_ADDR:0]   Busy_cnt
);

  localparam int unsigned N_REG = 2 ** N_ADDR;
  localparam int unsigned CNT_W = N_ADDR + 1;

  logic [N_BIT-1:0] mem_q [N_REG];
  logic [N_REG-1:0] busy_q;
  logic [N_REG-1:0] busy_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic wr_en;
  logic iss_en;
  logic cnt_inc;
  logic cnt_dec;
  logic same_reg;

  // Qualify write and issue requests; register 0 takes part in neither.
  always_comb begin
    wr_en    = Reg_write && (Wr_reg != '0);
    iss_en   = Iss_valid && (Iss_reg != '0);
    same_reg = wr_en && iss_en && (Wr_reg == Iss_reg);
  end

  // Next busy vector: write-clear first, issue-set overrides, flush clears all.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[Wr_reg] = 1'b0;
    end
    if (iss_en) begin
      busy_d[Iss_reg] = 1'b1;
    end
    if (Flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
  end

  // Pending count tracks only real 0->1 and 1->0 transitions of busy bits.
  always_comb begin
    cnt_inc = iss_en && !busy_q[Iss_reg];
    // A write to the register being re-issued leaves its bit set.
    cnt_dec = wr_en && busy_q[Wr_reg] && !same_reg;
    cnt_d   = cnt_q;
    if (Flush) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
    end
  end

  // Scoreboard state registers.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Register storage; writes to register 0 are dropped by wr_en.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < int'(N_REG); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[Wr_reg] <= Wr_data;
    end
  end

  // Combinational read ports, optionally forwarding the in-flight write.
  always_comb begin
    Rd_data_1 = (Rd_reg_1 == '0) ? '0 : mem_q[Rd_reg_1];
    Rd_data_2 = (Rd_reg_2 == '0) ? '0 : mem_q[Rd_reg_2];
    Rd_busy_1 = (Rd_reg_1 == '0) ? 1'b0 : busy_q[Rd_reg_1];
    Rd_busy_2 = (Rd_reg_2 == '0) ? 1'b0 : busy_q[Rd_reg_2];
`ifdef REG_BYPASS_EN
    if (wr_en && (Wr_reg == Rd_reg_1)) begin
      Rd_data_1 = Wr_data;
      Rd_busy_1 = same_reg;
    end
    if (wr_en && (Wr_reg == Rd_reg_2)) begin
      Rd_data_2 = Wr_data;
      Rd_busy_2 = same_reg;
    end
`endif
  end

  assign Busy_cnt = cnt_q;

endmodule

// File: doc/register_bank_sb.md
# register_bank_sb

Parametrised register bank with a per-register pending-write scoreboard for the RISC-V 32-bit core. It has two asynchronous read ports and one synchronous write port. Register 0 is hardwired to zero. A busy bit per register is set when an instruction that will write that register issues, and cleared when the write lands. The decode/issue stage uses it to detect RAW hazards, and the result bus uses it to retire writes. It is the next generation of the single-write, two-read register bank, generalised in width and depth.

## Interface
- N_ADDR, 5, register address bits
- N_BIT, 32, data bits per register
- N_REG, 2**N_ADDR, number of registers (derived; not overridden independently)

- Clk  input  1  clock; all state updates on rising edge
- Rst  input  1  synchronous, active-high reset
- Rd_reg_1  input  N_ADDR  read port 1 address
- Rd_reg_2  input  N_ADDR  read port 2 address
- Rd_data_1  output  N_BIT  read port 1 data
- Rd_data_2  output  N_BIT  read port 2 data
- Rd_busy_1  output  1  register at Rd_reg_1 has a pending write
- Rd_busy_2  output  1  register at Rd_reg_2 has a pending write
- Wr_reg  input  N_ADDR  write address
- Wr_data  input  N_BIT  write data
- Reg_write  input  1  write enable
- Iss_reg  input  N_ADDR  destination register of the issuing instruction
- Iss_valid  input  1  mark Iss_reg pending this cycle
- Flush  input  1  clear all busy bits (pipeline flush); data untouched
- Busy_cnt  output  N_ADDR+1  number of registers currently pending

## Operation
- Storage: N_REG × N_BIT array plus busy[N_REG-1:0] and a Busy_cnt counter.
- Write: on a rising edge with Reg_write=1 and Wr_reg≠0, mem[Wr_reg] ← Wr_data and busy[Wr_reg] ← 0.
  - Writes to register 0 are discarded.
  - A write to a non-busy register is legal; it updates data and busy stays 0.
- Issue: on a rising edge with Iss_valid=1 and Iss_reg≠0, busy[Iss_reg] ← 1. Issue to register 0 is ignored.
- Issue and write to the same register in the same cycle: data is written and busy ends at 1, because the new producer wins.
- Flush: busy ← 0 for all registers and Busy_cnt ← 0. Flush has priority over issue in the same cycle. A write in the same cycle still updates data.
- Reads: combinational. Rd_data_n = mem[Rd_reg_n], and Rd_busy_n = busy[Rd_reg_n]. Address 0 always reads data 0, busy 0.
- Busy_cnt: tracks the popcount of busy.
  - Incremented when an issue sets a previously clear bit.
  - Decremented when a write clears a set bit.
  - Net 0 when both happen to different registers.
  - Never exceeds N_REG-1.
- Priority per register per edge: Rst > Flush > issue-set > write-clear.

## Timing
- Reset: one Rst edge sets every register to 0, busy to 0 and Busy_cnt to 0. Consequently Rd_data_1/2 = 0, Rd_busy_1/2 = 0 and Busy_cnt = 0 from the cycle after Rst is sampled. Rst mid-operation discards any same-cycle write, issue or flush.
- Write latency: data is visible on the read ports one cycle after the write edge (no bypass), or in the same cycle (with bypass, see Configuration).
- Busy latency: Rd_busy rises the cycle after the Iss_valid edge and falls the cycle after the write edge.
- Busy_cnt is registered and updates on the same edge as the busy bits.

## Configuration
- REG_BYPASS_EN defined: write-through forwarding. When Reg_write=1, Wr_reg≠0 and Wr_reg==Rd_reg_n:
  - Rd_data_n = Wr_data combinationally.
  - Rd_busy_n = 0 in the same cycle, unless Iss_valid=1 with Iss_reg==Wr_reg, in which case Rd_busy_n = 1.
- REG_BYPASS_EN undefined: reads return only stored state, and same-cycle read-after-write returns old data and old busy.

## Test plan
- Reset then read all 32 addresses: every Rd_data = 0, Rd_busy = 0, Busy_cnt = 0.
- Write x9 = 32'h2453e and x3 = 32'h3423f on consecutive edges, then read Rd_reg_1=9, Rd_reg_2=3 → 32'h2453e and 32'h3423f. Write x0 = 32'hFFFF_FFFF → x0 still reads 0.
- Issue x5 → Rd_busy(5)=1, Busy_cnt=1. Write x5 = 32'hA5A5 → Rd_busy(5)=0, Busy_cnt=0, data 32'hA5A5. Same-edge issue x5 and write x5 = 32'h1 → data 32'h1, busy 1, Busy_cnt 1.
- Issue x1, x2 and x3, then Flush together with Iss_valid on x4 → all busy 0, Busy_cnt 0. Same-edge write to x7 still lands.
- With REG_BYPASS_EN: Reg_write=1, Wr_reg=9, Wr_data=32'hDEAD, Rd_reg_1=9 → Rd_data_1=32'hDEAD in the same cycle. Without the macro → old value until the next cycle.
- Rst asserted in the same cycle as a write of x6 = 32'h1234 and an issue of x6 → next cycle x6 reads 0, busy 0, Busy_cnt 0.
